// File: rtl/fp_mul_pipe_param.sv
// Parametrised pipelined floating-point multiplier with valid/ready flow control, tag and error sideband.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated toward zero.
module fp_mul_pipe_param #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 3,   // legal range 2..6
    parameter int TAG_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   float_in_1,
    input  logic [EXP_W+MAN_W:0]   float_in_2,
    input  logic [TAG_W-1:0]       tag_in,
    input  logic                   error_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   float_out,
    output logic [TAG_W-1:0]       tag_out,
    output logic                   error_out
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam int RW = 1 + TAG_W + W;
    localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;

    function automatic logic [MAN_W:0] round_man(input logic [MAN_W-1:0] man,
                                                 input logic guard, input logic sticky);
`ifdef FP_MUL_RNE_EN
        logic up;
        up = guard & (sticky | man[0]);
        return {1'b0, man} + {{MAN_W{1'b0}}, up};
`else
        return {1'b0, man} | {(MAN_W+1){1'b0 & (guard | sticky)}};
`endif
    endfunction

    // Returns {exception, packed float}; special operands take priority over range saturation.
    function automatic logic [W:0] pack_result(input logic sgn, input logic nan, input logic inf,
                                               input logic zero, input logic signed [EW-1:0] exp,
                                               input logic [MAN_W-1:0] man);
        logic [W:0] res;
        if (nan)
            res = {1'b1, 1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        else if (inf)
            res = {1'b0, sgn, EXP_ONES, {MAN_W{1'b0}}};
        else if (zero)
            res = {1'b0, sgn, {(EXP_W+MAN_W){1'b0}}};
        else if (exp >= EXP_MAX)
            res = {1'b1, sgn, EXP_ONES, {MAN_W{1'b0}}};
        else if (exp <= EXP_ZERO)
            res = {1'b1, sgn, {(EXP_W+MAN_W){1'b0}}};
        else
            res = {1'b0, sgn, exp[EXP_W-1:0], man};
        return res;
    endfunction

    logic                  w_adv;
    logic                  w_sgn_a, w_sgn_b;
    logic [EXP_W-1:0]      w_exp_a, w_exp_b;
    logic [MAN_W-1:0]      w_man_a, w_man_b;
    logic                  w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    logic signed [EW-1:0]  w_exp_sum;
    logic [PW-1:0]         w_prod;

    logic                  r_vld_p0;
    logic                  r_sgn_p0, r_nan_p0, r_inf_p0, r_zero_p0, r_err_p0;
    logic signed [EW-1:0]  r_exp_p0;
    logic [PW-1:0]         r_prod_p0;
    logic [TAG_W-1:0]      r_tag_p0;

    logic [PW-1:0]         w_norm_p1;
    logic signed [EW-1:0]  w_exp_norm_p1, w_exp_rnd_p1;
    logic [MAN_W-1:0]      w_man_trunc_p1, w_man_rnd_p1;
    logic                  w_guard_p1, w_sticky_p1, w_carry_p1;
    logic                  w_unused_p1;
    logic [W:0]            w_pack_p1;
    logic [RW-1:0]         w_res_p1;

    logic                  r_vld_p [1:STAGES-1];
    logic [RW-1:0]         r_res_p [1:STAGES-1];

    assign out_valid = r_vld_p[STAGES-1];
    assign w_adv     = ~out_valid | out_ready;
    assign in_ready  = w_adv & rst_n;
    assign {error_out, tag_out, float_out} = r_res_p[STAGES-1];

    // Stage 1: unpack, classify, exponent sum and full mantissa product
    assign {w_sgn_a, w_exp_a, w_man_a} = float_in_1;
    assign {w_sgn_b, w_exp_b, w_man_b} = float_in_2;
    assign w_nan_a   = (w_exp_a == EXP_ONES) && (w_man_a != '0);
    assign w_nan_b   = (w_exp_b == EXP_ONES) && (w_man_b != '0);
    assign w_inf_a   = (w_exp_a == EXP_ONES) && (w_man_a == '0);
    assign w_inf_b   = (w_exp_b == EXP_ONES) && (w_man_b == '0);
    assign w_zero_a  = (w_exp_a == '0);
    assign w_zero_b  = (w_exp_b == '0);
    assign w_exp_sum = $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b}) - BIAS;
    assign w_prod    = PW'({1'b1, w_man_a}) * PW'({1'b1, w_man_b});

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            r_sgn_p0  <= w_sgn_a ^ w_sgn_b;
            r_nan_p0  <= w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_inf_b & w_zero_a);
            r_inf_p0  <= w_inf_a | w_inf_b;
            r_zero_p0 <= w_zero_a | w_zero_b;
            r_exp_p0  <= w_exp_sum;
            r_prod_p0 <= w_prod;
            r_tag_p0  <= tag_in;
            r_err_p0  <= error_in;
        end
    end

    // Stage 2: normalise, round, pack; the product MSB after normalisation is the hidden bit
    assign w_norm_p1      = r_prod_p0[PW-1] ? r_prod_p0 : (r_prod_p0 << 1);
    assign w_exp_norm_p1  = r_prod_p0[PW-1] ? (r_exp_p0 + EXP_ONE) : r_exp_p0;
    assign w_man_trunc_p1 = w_norm_p1[PW-2 -: MAN_W];
    assign w_guard_p1     = w_norm_p1[PW-2-MAN_W];
    assign w_sticky_p1    = |w_norm_p1[PW-3-MAN_W:0];
    assign w_unused_p1    = w_norm_p1[PW-1];
    assign {w_carry_p1, w_man_rnd_p1} = round_man(w_man_trunc_p1, w_guard_p1, w_sticky_p1);
    assign w_exp_rnd_p1   = w_carry_p1 ? (w_exp_norm_p1 + EXP_ONE) : w_exp_norm_p1;
    assign w_pack_p1      = pack_result(r_sgn_p0, r_nan_p0, r_inf_p0, r_zero_p0,
                                        w_exp_rnd_p1, w_man_rnd_p1);
    assign w_res_p1       = {r_err_p0 | w_pack_p1[W], r_tag_p0, w_pack_p1[W-1:0]};

    // Stages 3..STAGES: plain delay of {error, tag, data}
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_p[STAGES-1] <= '0;
        end else if (w_adv) begin
            r_res_p[1] <= w_res_p1;
            for (int k = 2; k < STAGES; k++)
                r_res_p[k] <= r_res_p[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p0 <= 1'b0;
            for (int k = 1; k < STAGES; k++)
                r_vld_p[k] <= 1'b0;
        end else if (w_adv) begin
            r_vld_p0   <= in_valid;
            r_vld_p[1] <= r_vld_p0;
            for (int k = 2; k < STAGES; k++)
                r_vld_p[k] <= r_vld_p[k-1];
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe_param.sv
// Randomised scoreboard bench for fp_mul_pipe_param with a arithmetic reference model.
module tb_fp_mul_pipe_param;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int STAGES = 3;
    localparam int TAG_W  = 4;
    localparam int W      = 1 + EXP_W + MAN_W;
`ifdef FP_MUL_RNE_EN
    localparam logic [31:0] SQ_EXP = 32'h40100002;
`else
    localparam logic [31:0] SQ_EXP = 32'h40100001;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     float_in_1, float_in_2;
    logic [TAG_W-1:0] tag_in;
    logic             error_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     float_out;
    logic [TAG_W-1:0] tag_out;
    logic             error_out;

    typedef struct {
        logic [W-1:0]     f;
        logic [TAG_W-1:0] t;
        logic             e;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pops = 0;
    int   rmode = 0;
    int   rbase = 0;
    bit   stalled_seen = 0;

    fp_mul_pipe_param #(.EXP_W(EXP_W), .MAN_W(MAN_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .float_in_1(float_in_1), .float_in_2(float_in_2), .tag_in(tag_in), .error_in(error_in),
        .out_valid(out_valid), .out_ready(out_ready), .float_out(float_out),
        .tag_out(tag_out), .error_out(error_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer product, then round the value to 24 significant bits.
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic ein);
        int ea, eb, e, sh;
        longint sa, sbv, p, q, r, half;
        logic s;
        bit nan_a, nan_b, inf_a, inf_b, z_a, z_b;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        nan_a = (ea == 255) && (a[22:0] != 0);
        nan_b = (eb == 255) && (b[22:0] != 0);
        inf_a = (ea == 255) && (a[22:0] == 0);
        inf_b = (eb == 255) && (b[22:0] == 0);
        z_a = (ea == 0);
        z_b = (eb == 0);
        if (nan_a || nan_b || (inf_a && z_b) || (inf_b && z_a)) return {1'b1, 32'h7FC00000};
        if (inf_a || inf_b) return {ein, s, 8'hFF, 23'h0};
        if (z_a || z_b) return {ein, s, 31'h0};
        sa  = (longint'(1) << 23) + longint'(a[22:0]);
        sbv = (longint'(1) << 23) + longint'(b[22:0]);
        p = sa * sbv;
        if (p >= (longint'(1) << 47)) begin
            sh = 24; e = ea + eb - 127 + 1;
        end else begin
            sh = 23; e = ea + eb - 127;
        end
        q = p >> sh;
        r = p - (q << sh);
        half = longint'(1) << (sh - 1);
`ifdef FP_MUL_RNE_EN
        if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
`else
        if (r > half + p) q = q + 1;
`endif
        if (q == (longint'(1) << 24)) begin
            q = longint'(1) << 23;
            e = e + 1;
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
        if (e <= 0) return {1'b1, s, 31'h0};
        return {ein, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0: begin
                v[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) v[22:0] = 23'h0;
            end
            1: v[30:23] = 8'h00;
            2: v[30:23] = 8'($urandom_range(190, 254));
            3: v[30:23] = 8'($urandom_range(1, 60));
            4: v[22:0] = 23'h7FFFFF;
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                        input logic ein, input bit lat, input bit use_exp,
                        input logic [31:0] xf, input logic xe);
        int   guard;
        exp_t it;
        logic [32:0] m;
        float_in_1 = a; float_in_2 = b; tag_in = t; error_in = ein; in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready) begin
            stalled_seen = 1;
            guard++;
            if (guard > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout: in_ready stayed 0, want 1 within 200 cycles");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        m = ref_mul(a, b, ein);
        it.f = use_exp ? xf : m[31:0];
        it.e = use_exp ? xe : m[32];
        it.t = t;
        it.acc = cyc;
        it.lat = lat;
        sb.push_back(it);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, want 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: out_ready = !((cyc - rbase) >= 4 && (cyc - rbase) <= 8);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each consumed result, checks hold-stability while stalled.
    initial begin
        logic [W-1:0]     held_f;
        logic [TAG_W-1:0] held_t;
        logic             held_e;
        bit               held;
        exp_t             it;
        held = 0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (held) begin
                    checks++;
                    if ({float_out, tag_out, error_out} !== {held_f, held_t, held_e}) begin
                        errors++;
                        $display("FAIL stall_hold: got %h/%0d/%b, want %h/%0d/%b",
                                 float_out, tag_out, error_out, held_f, held_t, held_e);
                    end
                end
                if (out_ready) begin
                    held = 0;
                    pops++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %h tag %0d, want no result", float_out, tag_out);
                    end else begin
                        it = sb.pop_front();
                        if (float_out !== it.f || tag_out !== it.t || error_out !== it.e) begin
                            errors++;
                            $display("FAIL result: got f=%h tag=%0d err=%b, want f=%h tag=%0d err=%b",
                                     float_out, tag_out, error_out, it.f, it.t, it.e);
                        end
                        if (it.lat) begin
                            checks++;
                            if (cyc - it.acc != STAGES) begin
                                errors++;
                                $display("FAIL latency: got %0d cycles, want %0d", cyc - it.acc, STAGES);
                            end
                        end
                    end
                end else begin
                    held = 1;
                    held_f = float_out; held_t = tag_out; held_e = error_out;
                end
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        int p0;
        rst_n = 1'b0; in_valid = 1'b0; float_in_1 = '0; float_in_2 = '0; tag_in = '0; error_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_out_valid", 32'(out_valid), 32'd0);
        check1("rst_float_out", float_out, 32'h0);
        check1("rst_tag_out", 32'(tag_out), 32'd0);
        check1("rst_error_out", 32'(error_out), 32'd0);
        check1("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(32'h3FC00000, 32'h40000000, 4'd5, 1'b0, 1, 1, 32'h40400000, 1'b0);
        send(32'h3FC00001, 32'h3FC00001, 4'd1, 1'b0, 1, 1, SQ_EXP, 1'b0);
        send(32'h7F000000, 32'h7F000000, 4'd2, 1'b0, 1, 1, 32'h7F800000, 1'b1);
        send(32'h7F800000, 32'h00000000, 4'd3, 1'b0, 1, 1, 32'h7FC00000, 1'b1);
        send(32'h00400000, 32'h3F800000, 4'd4, 1'b0, 1, 1, 32'h00000000, 1'b0);
        send(32'h3F800000, 32'h3F800000, 4'd6, 1'b1, 1, 1, 32'h3F800000, 1'b1);
        send(32'hFF800000, 32'h40000000, 4'd7, 1'b0, 1, 1, 32'hFF800000, 1'b0);
        send(32'h00800000, 32'h00800000, 4'd8, 1'b0, 1, 1, 32'h00000000, 1'b1);
        send(32'h7FC00001, 32'hBF800000, 4'd9, 1'b0, 1, 1, 32'h7FC00000, 1'b1);
        send(32'hBFC00000, 32'h40000000, 4'd10, 1'b0, 1, 1, 32'hC0400000, 1'b0);
        drain();

        p0 = pops;
        stalled_seen = 0;
        rbase = cyc;
        rmode = 2;
        for (int i = 0; i < 8; i++)
            send({1'b0, 8'($urandom_range(110, 140)), 23'($urandom)},
                 {1'b1, 8'($urandom_range(110, 140)), 23'($urandom)},
                 4'(i), 1'b0, 0, 0, 32'h0, 1'b0);
        drain();
        rmode = 0;
        checks++;
        if (!stalled_seen) begin
            errors++;
            $display("FAIL bp_in_ready: got in_ready never low, want a drop while stalled");
        end
        check1("bp_count", 32'(pops - p0), 32'd8);

        send(32'h40000000, 32'h40000000, 4'd11, 1'b0, 0, 0, 32'h0, 1'b0);
        send(32'h40400000, 32'h40000000, 4'd12, 1'b0, 0, 0, 32'h0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check1("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check1("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        send(32'h3F800000, 32'h3FC00000, 4'd13, 1'b0, 1, 1, 32'h3FC00000, 1'b0);
        drain();

        for (int i = 0; i < 40; i++)
            send(rand_fp(), rand_fp(), 4'($urandom), 1'($urandom), 1, 0, 32'h0, 1'b0);
        drain();

        rmode = 1;
        for (int i = 0; i < 200; i++) begin
            send(rand_fp(), rand_fp(), 4'($urandom), 1'($urandom), 0, 0, 32'h0, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
